// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Holds the 3-bit FSM state encoding, the frame length and the default byte width.
// Imported by the interface, the bit-rate generator and the top level.
package uart_pkg;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_FETCH = 3'd1;
    localparam logic [2:0] ENC_LOAD  = 3'd2;
    localparam logic [2:0] ENC_START = 3'd3;
    localparam logic [2:0] ENC_DATA  = 3'd4;
    localparam logic [2:0] ENC_STOP  = 3'd5;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_FETCH = ENC_FETCH,
        ST_LOAD  = ENC_LOAD,
        ST_START = ENC_START,
        ST_DATA  = ENC_DATA,
        ST_STOP  = ENC_STOP
    } state_t;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read port of a synchronous FIFO as seen by the byte consumer.
// Data appears on fifo_data the cycle after fifo_rd_en is high.
// master = consumer issuing reads, slave = FIFO answering them.
interface uart_tx_drain_if import uart_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;

    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/uart_tx_drain_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: tick is decoded from the count register, high in the final cycle of a period.
// No backpressure; a synchronous clear holds the count at zero.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Next count: wrap at the end of a bit period, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from a sync FIFO whenever it is non-empty and sends each as 8N1, LSB first.
// Latency: !empty sampled at edge N -> rd_en high N..N+1, tx falls at N+2; frame = 10 bit periods.
// Backpressure: reads only after seeing !empty; a started frame always completes regardless of enable.
module uart_tx_drain import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    uart_tx_drain_if.master fifo,
    output logic            tx,
    output logic            busy,
    output logic            byte_done
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              tx_q;
    logic              tick;
    logic              baud_clr;

    // The timer only runs in the timed states; every entry into a timed state
    // comes either from an untimed state (count held at 0) or on a tick (count wraps to 0).
    assign baud_clr = !((state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP));

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (baud_clr),
        .tick_o (tick)
    );

    assign fifo.fifo_rd_en = (state_q == ST_FETCH);
    assign busy            = (state_q != ST_IDLE);
    assign byte_done       = (state_q == ST_STOP) && tick;
    assign tx              = tx_q;

    // Frame sequencer: state, bit counter, shift register and registered line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && !fifo.fifo_empty) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    // FIFO output is valid now, one cycle after the read strobe.
                    shift_q <= fifo.fifo_data;
                    tx_q    <= 1'b0;
                    state_q <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            // Next bit to present is the one just above the current LSB.
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (enable && !fifo.fifo_empty) begin
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a queue-based sync FIFO model on its read port.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_uart_tx_drain;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       tx;
    logic       busy;
    logic       byte_done;

    logic       push_vld = 1'b0;
    logic [7:0] push_dat = 8'h00;
    logic [7:0] fq [$];
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_empty_r = 1'b1;
    int         underflows = 0;

    int         cyc = 0;
    int         rd_cnt = 0;
    int         done_cnt = 0;

    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    uart_tx_drain_if #(.DATA_W(8)) bus ();
    assign bus.fifo_empty = fifo_empty_r;
    assign bus.fifo_data  = fifo_dout;

    uart_tx_drain #(
        .CLKS_PER_BIT (16),
        .DATA_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .fifo      (bus),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    // Sync FIFO model: registered data out and empty flag, underflow scoreboard.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            if (fq.size() == 0) underflows <= underflows + 1;
            else                fifo_dout <= fq.pop_front();
        end
        if (push_vld) fq.push_back(push_dat);
        fifo_empty_r <= (fq.size() == 0);
    end

    // Event counters sampled on the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (byte_done)      done_cnt <= done_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        push_vld = 1'b1;
        push_dat = d;
        tick(1);
        push_vld = 1'b0;
    endtask

    task automatic wait_tx_fall(input int limit, output bit ok);
        int i;
        i = 0;
        while (tx !== 1'b0 && i < limit) begin
            tick(1);
            i++;
        end
        ok = (tx === 1'b0);
    endtask

    task automatic wait_rd(input int limit, output bit ok);
        int i;
        i = 0;
        while (bus.fifo_rd_en !== 1'b1 && i < limit) begin
            tick(1);
            i++;
        end
        ok = (bus.fifo_rd_en === 1'b1);
    endtask

    // Called in the first cycle of a start bit; samples each bit mid-period, returns at mid-stop.
    task automatic rx_byte(output logic [7:0] b, output bit fok);
        fok = 1'b1;
        b = 8'h00;
        tick(8);
        if (tx !== 1'b0) fok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(16);
            b[i] = tx;
        end
        tick(16);
        if (tx !== 1'b1) fok = 1'b0;
    endtask

    task automatic test_reset();
        int rd0, badtx, badbusy;
        enable = 1'b1;
        #2 rst_n = 1'b0;
        tick(5);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.fifo_rd_en); end
        total++; if (byte_done !== 1'b0) begin bad++; $display("FAIL reset_byte_done got=%b want=0", byte_done); end
        rst_n = 1'b1;
        rd0 = rd_cnt;
        badtx = 0;
        badbusy = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (tx !== 1'b1) badtx++;
            if (busy !== 1'b0) badbusy++;
        end
        total++; if (badtx != 0) begin bad++; $display("FAIL idle_tx bad_cycles=%0d want=0", badtx); end
        total++; if (badbusy != 0) begin bad++; $display("FAIL idle_busy bad_cycles=%0d want=0", badbusy); end
        total++; if (rd_cnt - rd0 != 0) begin bad++; $display("FAIL idle_rd_en pulses=%0d want=0", rd_cnt - rd0); end
    endtask

    task automatic test_single();
        int rd0, dn0, bd_err;
        int errs [10];
        bit ok;
        logic [9:0] exp_frame;
        exp_frame = 10'b1000000010;  // stop, data 0x01 LSB first, start
        foreach (errs[k]) errs[k] = 0;
        bd_err = 0;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        push(8'h01);
        wait_rd(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_rd_seen got=0 want=1"); end
        tick(1);
        total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL single_rd_width got=%b want=0", bus.fifo_rd_en); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_load_tx got=%b want=1", tx); end
        tick(1);
        for (int c = 0; c < 160; c++) begin
            if (c > 0) tick(1);
            if (tx !== exp_frame[c / 16]) errs[c / 16]++;
            if ((c == 159) != (byte_done === 1'b1)) bd_err++;
        end
        for (int k = 0; k < 10; k++) begin
            total++; if (errs[k] != 0) begin bad++; $display("FAIL single_bit%0d bad_cycles=%0d want=0", k, errs[k]); end
        end
        total++; if (bd_err != 0) begin bad++; $display("FAIL single_byte_done_timing bad_cycles=%0d want=0", bd_err); end
        tick(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
        total++; if (rd_cnt - rd0 != 1) begin bad++; $display("FAIL single_rd_count got=%0d want=1", rd_cnt - rd0); end
        total++; if (done_cnt - dn0 != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt - dn0); end
        total++; if (fifo_empty_r !== 1'b1) begin bad++; $display("FAIL single_fifo_empty got=%b want=1", fifo_empty_r); end
    endtask

    task automatic test_back_to_back();
        int rd0, dn0, first, prev, fall;
        bit ok, fok;
        logic [7:0] b;
        enable = 1'b0;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        first = 0;
        prev = 0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        enable = 1'b1;
        for (int j = 0; j < 8; j++) begin
            wait_tx_fall(400, ok);
            total++; if (!ok) begin bad++; $display("FAIL b2b_start%0d got=timeout want=fall", j); end
            fall = cyc;
            if (j == 0) first = fall;
            else begin
                total++; if (fall - prev != 162) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=162", j, fall - prev); end
            end
            prev = fall;
            rx_byte(b, fok);
            total++; if (b !== 8'(j + 1)) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", j, b, 8'(j + 1)); end
            total++; if (!fok) begin bad++; $display("FAIL b2b_framing%0d got=bad want=ok", j); end
        end
        tick(8);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b want=0", busy); end
        total++; if (cyc - first != 8 * 160 + 14) begin bad++; $display("FAIL b2b_total got=%0d want=%0d", cyc - first, 8 * 160 + 14); end
        total++; if (rd_cnt - rd0 != 8) begin bad++; $display("FAIL b2b_rd_count got=%0d want=8", rd_cnt - rd0); end
        total++; if (done_cnt - dn0 != 8) begin bad++; $display("FAIL b2b_done_count got=%0d want=8", done_cnt - dn0); end
    endtask

    task automatic test_enable_drop();
        int rd0;
        bit ok, fok;
        logic [7:0] b;
        enable = 1'b0;
        rd0 = rd_cnt;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        enable = 1'b1;
        wait_tx_fall(400, ok);
        rx_byte(b, fok);
        total++; if (b !== 8'h01) begin bad++; $display("FAIL drop_byte1 got=%h want=01", b); end
        wait_tx_fall(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_start2 got=timeout want=fall"); end
        fork
            begin tick(40); enable = 1'b0; end
            begin rx_byte(b, fok); end
        join
        total++; if (b !== 8'h02 || !fok) begin bad++; $display("FAIL drop_byte2 got=%h ok=%b want=02 ok=1", b, fok); end
        tick(8);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle_busy got=%b want=0", busy); end
        tick(50);
        total++; if (rd_cnt - rd0 != 2) begin bad++; $display("FAIL drop_rd_count got=%0d want=2", rd_cnt - rd0); end
        total++; if (fq.size() != 1) begin bad++; $display("FAIL drop_fifo_level got=%0d want=1", fq.size()); end
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL drop_held tx=%b busy=%b want tx=1 busy=0", tx, busy); end
        enable = 1'b1;
        wait_tx_fall(50, ok);
        rx_byte(b, fok);
        total++; if (b !== 8'h03 || !fok || !ok) begin bad++; $display("FAIL drop_byte3 got=%h ok=%b want=03 ok=1", b, fok); end
        tick(8);
        total++; if (fifo_empty_r !== 1'b1) begin bad++; $display("FAIL drop_fifo_empty got=%b want=1", fifo_empty_r); end
    endtask

    task automatic test_reset_mid();
        int rel;
        bit ok, fok;
        logic [7:0] b;
        enable = 1'b1;
        push(8'h5A);
        push(8'hC3);
        wait_tx_fall(50, ok);
        tick(50);
        rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        tick(3);
        total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL midrst_rd_en got=%b want=0", bus.fifo_rd_en); end
        rst_n = 1'b1;
        rel = cyc;
        wait_tx_fall(50, ok);
        total++; if (cyc - rel != 3) begin bad++; $display("FAIL midrst_restart_latency got=%0d want=3", cyc - rel); end
        rx_byte(b, fok);
        total++; if (b !== 8'hC3 || !fok) begin bad++; $display("FAIL midrst_byte got=%h ok=%b want=c3 ok=1", b, fok); end
        tick(8);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_underflow();
        int rd0;
        bit ok, fok;
        logic [7:0] b;
        rd0 = rd_cnt;
        push(8'hA5);
        wait_tx_fall(50, ok);
        rx_byte(b, fok);
        total++; if (b !== 8'hA5 || !fok) begin bad++; $display("FAIL uflow_byte got=%h ok=%b want=a5 ok=1", b, fok); end
        tick(60);
        total++; if (rd_cnt - rd0 != 1) begin bad++; $display("FAIL uflow_rd_count got=%0d want=1", rd_cnt - rd0); end
        total++; if (underflows != 0) begin bad++; $display("FAIL uflow_reads_while_empty got=%0d want=0", underflows); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_underflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
